// File: rtl/jtmikie_psgseq_pkg.sv
// Shared definitions for the Mikie PSG write sequencer: FSM states, target
// select codes and the FIFO entry layout {sel, data}.
package jtmikie_psgseq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   localparam logic SEL_PSG1 = 1'b0;
   localparam logic SEL_PSG2 = 1'b1;

   localparam int ENTRY_W = 9;
   localparam int TCNT_W  = 6;

   typedef struct packed {
      logic       sel;
      logic [7:0] data;
   } entry_t;

endpackage

// File: rtl/jtmikie_psgseq_fifo.sv
// DEPTH x 9 register FIFO. A push while full is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and flagged.
module jtmikie_psgseq_fifo
   import jtmikie_psgseq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic               full,
   output logic               empty,
   output logic               drop
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign dout    = mem[rd_ptr];

   // NOTE: storage has no reset; the count alone defines what is valid, and
   // leaving the array unreset lets it map onto plain registers or LUT RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: non-blocking assignments keep every register update in this block
   // based on pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/jtmikie_psgseq.sv
// PSG write sequencer: buffers Z80 writes and replays them to one of two
// SN76489-style PSGs sharing a data latch, honouring each chip's cen/ready.
module jtmikie_psgseq
   import jtmikie_psgseq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TOUT  = 63
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen1,
   input  logic       cen2,
   input  logic       wr,
   input  logic       wr_sel,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       busy,
   output logic [7:0] psg_data,
   output logic       psg1_cs,
   output logic       psg2_cs,
   input  logic       rdy1,
   input  logic       rdy2,
   input  logic       clr,
   output logic       ovf,
   output logic       tmo
);

   localparam logic [TCNT_W-1:0] TOUT_LAST = TCNT_W'(TOUT - 1);

   state_t              state;
   state_t              state_nx;
   logic                tgt;
   logic [TCNT_W-1:0]   tcnt;
   logic                tcnt_clr;
   logic                t_cen;
   logic                t_rdy;
   logic                expire;
   logic                pop;
   logic                tmo_set;
   logic                ovf_set;
   logic                fifo_empty;
   entry_t              head;
   entry_t              push_entry;

   assign push_entry = '{sel: wr_sel, data: wr_data};

   jtmikie_psgseq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head),
      .full  (full),
      .empty (fifo_empty),
      .drop  (ovf_set)
   );

   assign t_cen  = (tgt == SEL_PSG2) ? cen2 : cen1;
   assign t_rdy  = (tgt == SEL_PSG2) ? rdy2 : rdy1;
   // Tick TOUT lands on the cen edge where the counter already shows TOUT-1.
   assign expire = t_cen && (tcnt == TOUT_LAST);
   assign busy   = !fifo_empty || (state != ST_IDLE);

   // NOTE: every output of this block is defaulted first so no path through
   // the case leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      tmo_set  = 1'b0;
      tcnt_clr = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nx = ST_ISSUE;
            tcnt_clr = 1'b1;
         end
         ST_ISSUE: begin
            if (t_cen && t_rdy) begin
               state_nx = ST_SETTLE;
               tcnt_clr = 1'b1;
            end else if (expire) begin
               state_nx = ST_IDLE;
               tmo_set  = 1'b1;
            end
         end
         ST_SETTLE: begin
            // Any cen seen here is already later than the take cen.
            if (t_cen && t_rdy) begin
               state_nx = ST_IDLE;
            end else if (expire) begin
               state_nx = ST_IDLE;
               tmo_set  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         tcnt  <= '0;
      end else begin
         state <= state_nx;
         if (tcnt_clr)   tcnt <= '0;
         else if (t_cen) tcnt <= tcnt + TCNT_W'(1);
      end
   end

   // The shared latch and the target only move on the pop edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psg_data <= 8'h00;
         tgt      <= SEL_PSG1;
      end else if (pop) begin
         psg_data <= head.data;
         tgt      <= head.sel;
      end
   end

   // Strobes are registered from the next state so they are glitch-free and
   // mutually exclusive by construction of the single target register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psg1_cs <= 1'b0;
         psg2_cs <= 1'b0;
      end else begin
         psg1_cs <= (state_nx == ST_ISSUE) && (tgt == SEL_PSG1);
         psg2_cs <= (state_nx == ST_ISSUE) && (tgt == SEL_PSG2);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         tmo <= 1'b0;
      end else begin
         if (ovf_set)  ovf <= 1'b1;
         else if (clr) ovf <= 1'b0;
         if (tmo_set)  tmo <= 1'b1;
         else if (clr) tmo <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtmikie_psgseq.sv
// Self-checking bench for jtmikie_psgseq: directed scenarios plus a random
// run scored against an in-order write queue.
module tb_jtmikie_psgseq;

   localparam int DEPTH = 4;
   localparam int TOUT  = 63;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       cen1    = 1'b0;
   logic       cen2    = 1'b0;
   logic       wr      = 1'b0;
   logic       wr_sel  = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rdy1    = 1'b0;
   logic       rdy2    = 1'b0;
   logic       clr     = 1'b0;
   logic       full;
   logic       busy;
   logic [7:0] psg_data;
   logic       psg1_cs;
   logic       psg2_cs;
   logic       ovf;
   logic       tmo;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int cen_mode = 0;

   logic [8:0] took_q [$];
   logic [8:0] exp_q  [$];

   logic       prev_cs1  = 1'b0;
   logic       prev_cs2  = 1'b0;
   logic       prev_cen1 = 1'b0;
   logic       prev_cen2 = 1'b0;
   logic [7:0] prev_data = 8'h00;

   jtmikie_psgseq #(
      .DEPTH (DEPTH),
      .TOUT  (TOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen1     (cen1),
      .cen2     (cen2),
      .wr       (wr),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .full     (full),
      .busy     (busy),
      .psg_data (psg_data),
      .psg1_cs  (psg1_cs),
      .psg2_cs  (psg2_cs),
      .rdy1     (rdy1),
      .rdy2     (rdy2),
      .clr      (clr),
      .ovf      (ovf),
      .tmo      (tmo)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after posedge; this monitor samples at negedge, where
   // the strobe and the cen/rdy about to be used at the next edge are stable.
   always @(negedge clk) begin
      if (rst_n) begin
         if (psg1_cs || psg2_cs) begin
            checks++;
            if (psg1_cs && psg2_cs) begin
               failures++;
               $display("FAIL cs_exclusive psg1_cs=%b psg2_cs=%b required not both", psg1_cs, psg2_cs);
            end
            if ((prev_cs1 || prev_cs2) && psg_data !== prev_data) begin
               failures++;
               $display("FAIL data_hold psg_data=%h required %h", psg_data, prev_data);
            end
         end
         if ((prev_cs1 && !psg1_cs && !prev_cen1) || (prev_cs2 && !psg2_cs && !prev_cen2)) begin
            checks++;
            failures++;
            $display("FAIL cs_drop_off_cen cen1=%b cen2=%b required the target cen=1", prev_cen1, prev_cen2);
         end
         if (psg1_cs && cen1 && rdy1) took_q.push_back({1'b0, psg_data});
         if (psg2_cs && cen2 && rdy2) took_q.push_back({1'b1, psg_data});
         prev_cs1  = psg1_cs;
         prev_cs2  = psg2_cs;
         prev_cen1 = cen1;
         prev_cen2 = cen2;
         prev_data = psg_data;
      end else begin
         prev_cs1 = 1'b0;
         prev_cs2 = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      wr = 1'b0;
      if (cen_mode == 0) begin
         cen1 = 1'b1;
         cen2 = (cyc % 2 == 0);
      end else begin
         cen1 = 1'($urandom_range(0, 1));
         cen2 = 1'($urandom_range(0, 1));
         rdy1 = ($urandom_range(0, 3) != 0);
         rdy2 = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic push(input logic sel, input logic [7:0] d);
      wr      = 1'b1;
      wr_sel  = sel;
      wr_data = d;
      step();
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_drain busy=%b required 0 within %0d cycles", name, busy, budget);
      end
   endtask

   task automatic wait_cs(input logic sel, input int budget, input string name);
      int n = 0;
      while (((sel ? psg2_cs : psg1_cs) !== 1'b1) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if ((sel ? psg2_cs : psg1_cs) !== 1'b1) begin
         failures++;
         $display("FAIL %s_cs_rise cs=0 required 1 within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({full, busy, psg1_cs, psg2_cs, ovf, tmo} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags full=%b busy=%b cs1=%b cs2=%b ovf=%b tmo=%b required all 0",
                  full, busy, psg1_cs, psg2_cs, ovf, tmo);
      end
      checks++;
      if (psg_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_data psg_data=%h required 00", psg_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_write();
      cen_mode = 0;
      rdy1 = 1'b1;
      rdy2 = 1'b1;
      took_q.delete();
      push(1'b0, 8'h9F);
      checks++;
      if (busy !== 1'b1 || psg1_cs !== 1'b0) begin
         failures++;
         $display("FAIL single_after_push busy=%b cs1=%b required 1 0", busy, psg1_cs);
      end
      step();
      checks++;
      if (psg_data !== 8'h9F || psg1_cs !== 1'b0) begin
         failures++;
         $display("FAIL single_pop psg_data=%h cs1=%b required 9f 0", psg_data, psg1_cs);
      end
      step();
      checks++;
      if (psg1_cs !== 1'b1 || psg2_cs !== 1'b0) begin
         failures++;
         $display("FAIL single_strobe cs1=%b cs2=%b required 1 0", psg1_cs, psg2_cs);
      end
      step();
      checks++;
      if (psg1_cs !== 1'b0) begin
         failures++;
         $display("FAIL single_strobe_width cs1=%b required 0", psg1_cs);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_busy_end busy=%b required 0", busy);
      end
      checks++;
      if (took_q.size() != 1 || took_q[0] !== 9'h09F) begin
         failures++;
         $display("FAIL single_taken count=%0d first=%h required 1 09f", took_q.size(),
                  (took_q.size() > 0) ? took_q[0] : 9'h000);
      end
   endtask

   task automatic test_alternating();
      cen_mode = 0;
      rdy1 = 1'b1;
      rdy2 = 1'b1;
      took_q.delete();
      exp_q = '{9'h080, 9'h181, 9'h082, 9'h183};
      for (int i = 0; i < 4; i++) push(exp_q[i][8], exp_q[i][7:0]);
      wait_idle(100, "alt");
      checks++;
      if (took_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL alt_count writes=%0d required %0d", took_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (took_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL alt_write%0d got=%h required %h", i, took_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      cen_mode = 0;
      rdy1 = 1'b0;
      took_q.delete();
      for (int i = 0; i < 6; i++) push(1'b0, 8'h10 + 8'(i));
      checks++;
      if (ovf !== 1'b1 || full !== 1'b1) begin
         failures++;
         $display("FAIL ovf_flags ovf=%b full=%b required 1 1", ovf, full);
      end
      rdy1 = 1'b1;
      wait_idle(100, "ovf");
      exp_q = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014};
      checks++;
      if (took_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL ovf_count writes=%0d required %0d", took_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (took_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL ovf_write%0d got=%h required %h", i, took_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky ovf=%b required 1", ovf);
      end
      pulse_clr();
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear ovf=%b required 0", ovf);
      end
   endtask

   task automatic test_timeout();
      int ticks = 0;
      int n = 0;
      cen_mode = 0;
      rdy1 = 1'b1;
      rdy2 = 1'b0;
      took_q.delete();
      push(1'b1, 8'hA5);
      wait_cs(1'b1, 10, "tmo");
      while (psg2_cs === 1'b1 && n < 4 * TOUT) begin
         if (cen2) ticks++;
         step();
         n++;
      end
      checks++;
      if (ticks != TOUT) begin
         failures++;
         $display("FAIL tmo_ticks ticks=%0d required %0d", ticks, TOUT);
      end
      checks++;
      if (tmo !== 1'b1 || psg2_cs !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL tmo_abort tmo=%b cs2=%b busy=%b required 1 0 0", tmo, psg2_cs, busy);
      end
      checks++;
      if (took_q.size() != 0) begin
         failures++;
         $display("FAIL tmo_no_write writes=%0d required 0", took_q.size());
      end
      pulse_clr();
      checks++;
      if (tmo !== 1'b0) begin
         failures++;
         $display("FAIL tmo_clear tmo=%b required 0", tmo);
      end
      rdy2 = 1'b1;
   endtask

   task automatic test_reset_issue();
      cen_mode = 0;
      rdy1 = 1'b0;
      push(1'b0, 8'h55);
      push(1'b0, 8'h56);
      push(1'b0, 8'h57);
      wait_cs(1'b0, 10, "rst");
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (psg1_cs !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
         failures++;
         $display("FAIL rst_async cs1=%b busy=%b full=%b required 0 0 0", psg1_cs, busy, full);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rdy1 = 1'b1;
      took_q.delete();
      repeat (20) step();
      checks++;
      if (took_q.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_no_write writes=%0d busy=%b required 0 0", took_q.size(), busy);
      end
   endtask

   task automatic test_full_push_pop();
      cen_mode = 0;
      pulse_clr();
      rdy1 = 1'b0;
      took_q.delete();
      for (int i = 0; i < 5; i++) push(1'b0, 8'h20 + 8'(i));
      checks++;
      if (full !== 1'b1 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL fpp_fill full=%b ovf=%b required 1 0", full, ovf);
      end
      // Take, then SETTLE->IDLE; the third edge is the IDLE pop.
      rdy1 = 1'b1;
      step();
      step();
      push(1'b0, 8'h25);
      checks++;
      if (full !== 1'b1 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL fpp_accept full=%b ovf=%b required 1 0", full, ovf);
      end
      wait_idle(100, "fpp");
      exp_q = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h024, 9'h025};
      checks++;
      if (took_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL fpp_count writes=%0d required %0d", took_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (took_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL fpp_write%0d got=%h required %h", i, took_q[i], exp_q[i]);
            end
         end
      end
   endtask

   // Bursts of at most DEPTH writes into an idle block are never dropped, so
   // the expected output is simply every pushed byte in push order.
   task automatic test_random();
      took_q.delete();
      exp_q.delete();
      cen_mode = 1;
      for (int b = 0; b < 30; b++) begin
         int n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            logic       s = 1'($urandom_range(0, 1));
            logic [7:0] d = 8'($urandom_range(0, 255));
            exp_q.push_back({s, d});
            push(s, d);
            repeat ($urandom_range(0, 2)) step();
         end
         wait_idle(400, "rand");
      end
      cen_mode = 0;
      checks++;
      if (took_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL rand_count writes=%0d required %0d", took_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (took_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL rand_write%0d got=%h required %h", i, took_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (ovf !== 1'b0 || tmo !== 1'b0) begin
         failures++;
         $display("FAIL rand_flags ovf=%b tmo=%b required 0 0", ovf, tmo);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_alternating();
      test_overflow();
      test_timeout();
      test_reset_issue();
      test_full_push_pop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jtmikie_psgseq.md
# jtmikie_psgseq

PSG write sequencer for the Mikie sound board. It sits between the sound Z80 and the two SN76489-compatible PSGs, which share a single 8-bit data latch. It buffers CPU writes in a small FIFO. It then issues each write to the selected PSG on that chip's clock enable, waiting for the chip's ready line, so the CPU never stalls on PSG ready and the shared data latch never changes under an in-flight write.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- TOUT, 63, max target-cen ticks to wait in any waiting state before abort; 6-bit counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen1  in  1  PSG1 clock enable (3.58 MHz)
- cen2  in  1  PSG2 clock enable (1.79 MHz)
- wr  in  1  one-cycle push strobe from CPU decode
- wr_sel  in  1  target: 0 = PSG1, 1 = PSG2
- wr_data  in  8  byte to write
- full  out  1  FIFO full
- busy  out  1  FIFO non-empty or state ≠ IDLE
- psg_data  out  8  shared PSG data bus
- psg1_cs  out  1  PSG1 write strobe, active-high
- psg2_cs  out  1  PSG2 write strobe, active-high
- rdy1  in  1  PSG1 ready
- rdy2  in  1  PSG2 ready
- clr  in  1  clears sticky flags
- ovf  out  1  sticky: push dropped
- tmo  out  1  sticky: write aborted on timeout

## Operation
- **FIFO push:** a push on `wr` stores {wr_sel, wr_data}.
  - A push while full with no pop in the same cycle is dropped and sets ovf.
  - A push and a pop in the same cycle while full are both accepted; the count is unchanged.
- **States:** IDLE, LOAD, ISSUE, SETTLE.
- **IDLE:** when the FIFO is non-empty, pop the head. psg_data and the target register latch the head at that edge. Go to LOAD.
- **LOAD:** one cycle that lets psg_data settle. Go to ISSUE.
- **ISSUE:** assert the target cs.
  - The write is taken on the first cycle where target cen=1 and target rdy=1. On that cycle cs stays high; it drops at the next edge, and the state goes to SETTLE.
- **SETTLE:** wait for a target cen cycle where target rdy=1, at least one target cen after the take. Then go to IDLE.
- **Timeout:** the counter clears on entry to ISSUE and SETTLE and increments on each target cen.
  - When it reaches TOUT in either state, go to IDLE with cs low and set tmo.
  - The aborted byte is discarded.
- **psg_data hold:** psg_data changes only on the IDLE pop edge and holds its value otherwise.
- **Exclusive strobes:** psg1_cs and psg2_cs are never high together.
- **Sticky flags:** clr clears ovf and tmo. A set event in the same cycle as clr wins.

## Timing
- **Reset values:** all outputs are 0 at reset (full, busy, psg_data, psg1_cs, psg2_cs, ovf, tmo). The FIFO is emptied and the state is IDLE.
- **Push-to-strobe latency:** push at edge N into an empty, idle block gives:
  - busy=1 after edge N;
  - pop at edge N+1, with psg_data valid after N+1;
  - LOAD during N+1..N+2;
  - cs high after edge N+2.
- **Minimum per-write cost:** with rdy high and cen every cycle, the sequence is IDLE, LOAD, ISSUE, SETTLE, giving 4 clk per write. Back-to-back writes go straight from IDLE to a pop.
- **full:** combinational from the count, updated the cycle after the push/pop edge.
- **Mid-operation reset:** rst_n low asynchronously forces cs low immediately and discards FIFO contents.

## Structure
- Shared package/header: state encodings (IDLE=0, LOAD=1, ISSUE=2, SETTLE=3), target select constants (SEL_PSG1=0, SEL_PSG2=1), FIFO entry width (9).
- One sub-module, `jtmikie_psgseq_fifo`: DEPTH×9 register FIFO with push/pop, full/empty and the simultaneous push/pop rule.
- The top level holds the FSM, timeout counter, cen/rdy muxing by target, and sticky flags.

## Test plan
- **Single write:** cen1 every cycle, rdy1=1, push sel=0 data=8'h9F.
  - Expected: psg1_cs high for exactly 1 cycle starting 2 cycles after the push, psg_data=8'h9F, psg2_cs never high, busy back to 0 after SETTLE.
- **Alternating targets:** 4 alternating-target pushes (8'h80, 8'h81, 8'h82, 8'h83), cen2 every 2nd cycle.
  - Expected: strobes in push order, never overlapping; each psg2_cs take coincides with cen2=1.
- **Overflow:** DEPTH=4, 6 pushes in consecutive cycles while rdy1 is held low.
  - Expected: 1 popped plus 4 buffered, 1 dropped, ovf=1, full=1. After rdy1 rises, all 5 kept bytes are written in order.
- **Timeout:** rdy2 held low, push sel=1.
  - Expected: tmo=1 after 63 cen2 ticks, psg2_cs low, busy=0. clr then returns tmo to 0.
- **Reset during ISSUE:** rst_n low while psg1_cs=1.
  - Expected: psg1_cs=0 in the same cycle, FIFO empty, no write issued after release.
- **Full with simultaneous push/pop:** push while full in the same cycle as the IDLE pop.
  - Expected: accepted, ovf stays 0, count stays DEPTH.
